// File: rtl/seq_alu_pkg.sv
// -----------------------------------------------------------------------------
// seq_alu_pkg
// Shared definitions for the sequential ALU core:
//   OP_W              opcode width (3 bits)
//   OP_ADD .. OP_XOR  opcode values
//   state_t           controller states (IDLE, MUL, DONE)
// -----------------------------------------------------------------------------
package seq_alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
  localparam logic [OP_W-1:0] OP_NEGA = 3'd2;
  localparam logic [OP_W-1:0] OP_NEGB = 3'd3;
  localparam logic [OP_W-1:0] OP_MUL  = 3'd4;
  localparam logic [OP_W-1:0] OP_AND  = 3'd5;
  localparam logic [OP_W-1:0] OP_OR   = 3'd6;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_alu_mult.sv
// -----------------------------------------------------------------------------
// seq_alu_mult
// Iterative shift-add multiplier, one partial product per step, LSB of b first.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   load         latch a and b, clear accumulator and step counter
//   step         add the current partial product and advance one bit
//   a, b         WIDTH-bit unsigned operands (sampled on load)
//   product      2*WIDTH-bit value the accumulator takes on the current step;
//                equals the full product while last is high
//   last         the current step is the final (WIDTH-th) one
// -----------------------------------------------------------------------------
module seq_alu_mult #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_reg;  // multiplicand, shifted left each step
  logic [WIDTH-1:0]   mplier_reg; // multiplier, shifted right each step
  logic [2*WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [2*WIDTH-1:0] addend;

  // Partial product: multiplicand gated by the current multiplier bit.
  genvar gi;
  generate
    for (gi = 0; gi < 2*WIDTH; gi++) begin : g_pp
      assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
    end
  endgenerate

  // Exposed combinationally so the controller can register the finished
  // product on the same edge as the final step.
  assign product = acc_reg + addend;
  assign last    = (count_reg == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
    end else if (load) begin
      mcand_reg  <= {{WIDTH{1'b0}}, a};
      mplier_reg <= b;
      acc_reg    <= '0;
      count_reg  <= '0;
    end else if (step) begin
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      acc_reg    <= product;
      count_reg  <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_alu_core.sv
// -----------------------------------------------------------------------------
// seq_alu_core
// Clocked ALU: one operation per start/done handshake, registered result+flags.
// MUL iterates WIDTH cycles in seq_alu_mult; every other op completes in one.
// Optional feature macro: SEQ_ALU_ACCUM_EN (adds acc_sel, chains result into A).
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   acc_sel      (SEQ_ALU_ACCUM_EN only) use result[WIDTH-1:0] as operand A
//   start        request, sampled only while not busy
//   op, a, b     opcode and operands, sampled with start
//   busy         high during MUL iteration
//   done         one-cycle pulse when result/carry/zero were updated
//   result       2*WIDTH-bit registered result, held until the next done
//   carry        ADD carry-out / SUB borrow, 0 for other ops
//   zero         result == 0
// -----------------------------------------------------------------------------
module seq_alu_core
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef SEQ_ALU_ACCUM_EN
  input  logic               acc_sel,
`endif
  input  logic               start,
  input  logic [OP_W-1:0]    op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               zero
);

  state_t state_reg, state_next;

  logic [2*WIDTH-1:0] result_reg;
  logic               carry_reg;
  logic               zero_reg;

  logic               mul_load;
  logic               mul_step;
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH-1:0]   opa;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [WIDTH-1:0]   alu_val;
  logic               alu_carry;
  logic               accept_single;

`ifdef SEQ_ALU_ACCUM_EN
  assign opa = acc_sel ? result_reg[WIDTH-1:0] : a;
`else
  assign opa = a;
`endif

  // One extra bit exposes ADD carry-out; for SUB the same bit is set exactly
  // when opa < b (the difference wrapped), i.e. the borrow.
  assign sum_ext  = {1'b0, opa} + {1'b0, b};
  assign diff_ext = {1'b0, opa} - {1'b0, b};

  always_comb begin
    alu_val   = '0;
    alu_carry = 1'b0;
    case (op)
      OP_ADD:  begin alu_val = sum_ext[WIDTH-1:0];  alu_carry = sum_ext[WIDTH];  end
      OP_SUB:  begin alu_val = diff_ext[WIDTH-1:0]; alu_carry = diff_ext[WIDTH]; end
      OP_NEGA: alu_val = '0 - opa;
      OP_NEGB: alu_val = '0 - b;
      OP_AND:  alu_val = opa & b;
      OP_OR:   alu_val = opa | b;
      OP_XOR:  alu_val = opa ^ b;
      default: ;
    endcase
  end

  // Controller: requests are only looked at outside MUL, so a start while
  // busy never reaches the operand latches or the result registers.
  always_comb begin
    state_next    = ST_IDLE;
    mul_load      = 1'b0;
    mul_step      = 1'b0;
    accept_single = 1'b0;
    case (state_reg)
      ST_MUL: begin
        mul_step   = 1'b1;
        state_next = mul_last ? ST_DONE : ST_MUL;
      end
      default: begin  // ST_IDLE and ST_DONE accept identically
        if (start) begin
          if (op == OP_MUL) begin
            mul_load   = 1'b1;
            state_next = ST_MUL;
          end else begin
            accept_single = 1'b1;
            state_next    = ST_DONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= '0;
      carry_reg  <= 1'b0;
      zero_reg   <= 1'b0;
    end else if (accept_single) begin
      result_reg <= {{WIDTH{1'b0}}, alu_val};
      carry_reg  <= alu_carry;
      zero_reg   <= (alu_val == '0);
    end else if (mul_step && mul_last) begin
      result_reg <= mul_product;
      carry_reg  <= 1'b0;
      zero_reg   <= (mul_product == '0);
    end
  end

  seq_alu_mult #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (mul_load),
    .step    (mul_step),
    .a       (opa),
    .b       (b),
    .product (mul_product),
    .last    (mul_last)
  );

  assign busy   = (state_reg == ST_MUL);
  assign done   = (state_reg == ST_DONE);
  assign result = result_reg;
  assign carry  = carry_reg;
  assign zero   = zero_reg;

endmodule
